// File: rtl/matrix_pe_mp.sv
// matrix_pe_mp: multi-precision dot-product accumulator.
//
// Accepts one micro-op, then N joint beats of neuron/weight vectors. Each beat is
// multiplied lane-wise (int16 or int8 signed lanes), reduced to one partial sum
// (stage 1), then added into the accumulator (stage 2). The final accumulator is
// presented on a valid/ready result port, optionally saturated to RES_W bits.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ib_ctl_uop[_valid/_ready]      micro-op {.., sat, mode, N[CNT_W-1:0]}
//   nram_mpe_neuron[_valid/_ready] neuron vector stream
//   wram_mpe_weight[_valid/_ready] weight vector stream
//   result[_valid/_ready]          RES_W-bit dot-product result

module matrix_pe_mp #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned CNT_W  = 6,
  parameter int unsigned UOP_W  = 8,
  parameter int unsigned ACC_W  = 48,
  parameter int unsigned RES_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [UOP_W-1:0]  ib_ctl_uop,
  input  logic              ib_ctl_uop_valid,
  output logic              ib_ctl_uop_ready,
  input  logic [DATA_W-1:0] nram_mpe_neuron,
  input  logic              nram_mpe_neuron_valid,
  output logic              nram_mpe_neuron_ready,
  input  logic [DATA_W-1:0] wram_mpe_weight,
  input  logic              wram_mpe_weight_valid,
  output logic              wram_mpe_weight_ready,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int unsigned Lanes16 = DATA_W / 16;
  localparam int unsigned Lanes8  = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [CNT_W-1:0]   r_n;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_mode;
  logic               r_sat;
  logic               r_rst_q;
  logic [ACC_W-1:0]   r_psum;
  logic               r_psum_vld;
  logic [ACC_W-1:0]   r_acc;

  logic               w_uop_fire;
  logic               w_beat_fire;
  logic               w_last_beat;
  logic [ACC_W-1:0]   w_sum16;
  logic [ACC_W-1:0]   w_sum8;
  logic               w_ovf;
  logic [RES_W-1:0]   w_res;

  assign w_uop_fire  = ib_ctl_uop_valid && ib_ctl_uop_ready;
  assign w_beat_fire = (r_state == StAcc) && nram_mpe_neuron_valid && wram_mpe_weight_valid;
  assign w_last_beat = (r_cnt == r_n - 1'b1);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_uop_fire) begin
          w_state_next = (ib_ctl_uop[CNT_W-1:0] == '0) ? StDone : StAcc;
        end
      end
      StAcc: begin
        if (w_beat_fire && w_last_beat) w_state_next = StDrain;
      end
      // Wait for the last partial sum to land in the accumulator.
      StDrain: begin
        if (!r_psum_vld) w_state_next = StDone;
      end
      StDone: begin
        if (result_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    // Hold uop_ready low for the cycle after a reset so a reset pulse leaves
    // every output quiet for one full cycle.
    ib_ctl_uop_ready      = (r_state == StIdle) && !rst && !r_rst_q;
    nram_mpe_neuron_ready = (r_state == StAcc) && wram_mpe_weight_valid;
    wram_mpe_weight_ready = (r_state == StAcc) && nram_mpe_neuron_valid;
    result_valid          = (r_state == StDone);
    result                = (r_state == StDone) ? w_res : '0;
  end

  // Lane-wise products reduced to a sign-extended partial sum, both precisions.
  always_comb begin : p_sum16
    logic signed [31:0] w_prod16;
    w_prod16 = '0;
    w_sum16  = '0;
    for (int i = 0; i < Lanes16; i++) begin
      w_prod16 = $signed(nram_mpe_neuron[i*16 +: 16]) * $signed(wram_mpe_weight[i*16 +: 16]);
      w_sum16  = w_sum16 + {{(ACC_W-32){w_prod16[31]}}, w_prod16};
    end
  end

  always_comb begin : p_sum8
    logic signed [15:0] w_prod8;
    w_prod8 = '0;
    w_sum8  = '0;
    for (int i = 0; i < Lanes8; i++) begin
      w_prod8 = $signed(nram_mpe_neuron[i*8 +: 8]) * $signed(wram_mpe_weight[i*8 +: 8]);
      w_sum8  = w_sum8 + {{(ACC_W-16){w_prod8[15]}}, w_prod8};
    end
  end

  // Control, stage 1 (partial sum) and stage 2 (accumulate)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n        <= '0;
      r_cnt      <= '0;
      r_mode     <= 1'b0;
      r_sat      <= 1'b0;
      r_psum     <= '0;
      r_psum_vld <= 1'b0;
      r_acc      <= '0;
      r_rst_q    <= 1'b1;
    end else begin
      r_rst_q    <= 1'b0;
      r_psum_vld <= w_beat_fire;
      if (w_uop_fire) begin
        r_n    <= ib_ctl_uop[CNT_W-1:0];
        r_mode <= ib_ctl_uop[CNT_W];
        r_sat  <= ib_ctl_uop[CNT_W+1];
        r_cnt  <= '0;
        r_acc  <= '0;
      end else begin
        if (w_beat_fire) r_cnt <= r_cnt + 1'b1;
        if (r_psum_vld) r_acc <= r_acc + r_psum;
      end
      if (w_beat_fire) r_psum <= r_mode ? w_sum8 : w_sum16;
    end
  end

  // Overflow when the bits above the result sign bit are not all copies of it.
  assign w_ovf = !(&r_acc[ACC_W-1:RES_W-1]) && (|r_acc[ACC_W-1:RES_W-1]);

  always_comb begin
    w_res = r_acc[RES_W-1:0];
    if (r_sat && w_ovf) begin
      w_res = r_acc[ACC_W-1] ? {1'b1, {(RES_W-1){1'b0}}} : {1'b0, {(RES_W-1){1'b1}}};
    end
  end

endmodule

// File: tb/tb_matrix_pe_mp.sv
module tb_matrix_pe_mp;

  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    uop = '0;
  logic          uop_valid = 1'b0;
  logic          uop_ready;
  logic [DW-1:0] neuron = '0;
  logic          n_valid = 1'b0;
  logic          n_ready;
  logic [DW-1:0] weight = '0;
  logic          w_valid = 1'b0;
  logic          w_ready;
  logic [31:0]   result;
  logic          result_valid;
  logic          result_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int n_fires = 0;
  int w_fires = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  matrix_pe_mp dut (
    .clk                   (clk),
    .rst                   (rst),
    .ib_ctl_uop            (uop),
    .ib_ctl_uop_valid      (uop_valid),
    .ib_ctl_uop_ready      (uop_ready),
    .nram_mpe_neuron       (neuron),
    .nram_mpe_neuron_valid (n_valid),
    .nram_mpe_neuron_ready (n_ready),
    .wram_mpe_weight       (weight),
    .wram_mpe_weight_valid (w_valid),
    .wram_mpe_weight_ready (w_ready),
    .result                (result),
    .result_valid          (result_valid),
    .result_ready          (result_ready)
  );

  // Monitor: counts stream consumption and checks results against the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (n_valid && n_ready) n_fires++;
        if (w_valid && w_ready) w_fires++;
        if ((n_valid && n_ready) || (w_valid && w_ready)) begin
          checks++;
          if ((n_valid && n_ready) != (w_valid && w_ready)) begin
            failures++;
            $display("FAIL lone_consume: neuron_fire=%0b weight_fire=%0b required equal",
                     n_valid && n_ready, w_valid && w_ready);
          end
        end
        if (result_valid && result_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_result: got %h, required no result", result);
          end else begin
            e = exp_q.pop_front();
            if (result !== e) begin
              failures++;
              $display("FAIL result: got %h, required %h", result, e);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, expv);
    end
  endtask

  task automatic send_uop(input int n, input bit mode, input bit sat);
    bit hs = 0;
    int g = 0;
    uop = {sat, mode, 6'(n)};
    uop_valid = 1'b1;
    do begin
      @(negedge clk);
      hs = uop_valid && uop_ready;
      @(posedge clk);
      #1;
      g++;
    end while (!hs && g < 200);
    uop_valid = 1'b0;
    if (!hs) chk("uop_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_beats(input int n, input logic [DW-1:0] nv, input logic [DW-1:0] wv,
                            input bit rnd);
    int done = 0;
    int g = 0;
    bit f;
    neuron = nv;
    weight = wv;
    while (done < n && g < 1000) begin
      n_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      w_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      f = n_valid && n_ready && w_valid && w_ready;
      @(posedge clk);
      #1;
      if (f) done++;
      g++;
    end
    n_valid = 1'b0;
    w_valid = 1'b0;
    if (done < n) chk("beat_timeout", 32'(done), 32'(n));
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_q.size() != 0 || result_valid) && g < 300) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_uop_ready"}, 32'(uop_ready), 32'd0);
    chk({name, "_n_ready"}, 32'(n_ready), 32'd0);
    chk({name, "_w_ready"}, 32'(w_ready), 32'd0);
    chk({name, "_result_valid"}, 32'(result_valid), 32'd0);
    chk({name, "_result"}, result, 32'd0);
  endtask

  initial begin
    int nf0;
    int wf0;
    int g;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    n_valid = 1'b1;
    w_valid = 1'b1;
    #1;
    chk_quiet("reset");
    n_valid = 1'b0;
    w_valid = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // int16 N=1, 1*2 per lane, 32 lanes -> 64; valid exactly two edges after fire
    exp_q.push_back(32'h0000_0040);
    send_uop(1, 1'b0, 1'b0);
    send_beats(1, {(DW/16){16'h0001}}, {(DW/16){16'h0002}}, 1'b0);
    chk("lat_fire_edge", 32'(result_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_plus1", 32'(result_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lat_plus2", 32'(result_valid), 32'd1);
    wait_idle();

    // int8 N=2, (-1)*3 per lane, 64 lanes, 2 beats -> -384
    exp_q.push_back(32'hFFFF_FE80);
    send_uop(2, 1'b1, 1'b0);
    send_beats(2, {(DW/8){8'hFF}}, {(DW/8){8'h03}}, 1'b0);
    wait_idle();

    // Same with independently randomised valids
    nf0 = n_fires;
    wf0 = w_fires;
    exp_q.push_back(32'hFFFF_FE80);
    send_uop(2, 1'b1, 1'b0);
    send_beats(2, {(DW/8){8'hFF}}, {(DW/8){8'h03}}, 1'b1);
    wait_idle();
    chk("rand_n_beats", 32'(n_fires - nf0), 32'd2);
    chk("rand_w_beats", 32'(w_fires - wf0), 32'd2);

    // 0x7FFF^2 * 32 = 0x7_FFE0_0020: saturate vs wrap
    exp_q.push_back(32'h7FFF_FFFF);
    send_uop(1, 1'b0, 1'b1);
    send_beats(1, {(DW/16){16'h7FFF}}, {(DW/16){16'h7FFF}}, 1'b0);
    wait_idle();
    exp_q.push_back(32'hFFE0_0020);
    send_uop(1, 1'b0, 1'b0);
    send_beats(1, {(DW/16){16'h7FFF}}, {(DW/16){16'h7FFF}}, 1'b0);
    wait_idle();

    // -32768*32767*32 = -0x7_FFF0_0000: negative clamp vs wrap
    exp_q.push_back(32'h8000_0000);
    send_uop(1, 1'b0, 1'b1);
    send_beats(1, {(DW/16){16'h8000}}, {(DW/16){16'h7FFF}}, 1'b0);
    wait_idle();
    exp_q.push_back(32'h0010_0000);
    send_uop(1, 1'b0, 1'b0);
    send_beats(1, {(DW/16){16'h8000}}, {(DW/16){16'h7FFF}}, 1'b0);
    wait_idle();

    // Backpressure: 1*5*32 = 160
    result_ready = 1'b0;
    exp_q.push_back(32'h0000_00A0);
    send_uop(1, 1'b0, 1'b0);
    send_beats(1, {(DW/16){16'h0001}}, {(DW/16){16'h0005}}, 1'b0);
    n_valid = 1'b1;
    w_valid = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!result_valid && g < 20);
    for (int k = 0; k < 5; k++) begin
      chk("bp_result", result, 32'h0000_00A0);
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_uop_ready", 32'(uop_ready), 32'd0);
      chk("bp_n_ready", 32'(n_ready), 32'd0);
      chk("bp_w_ready", 32'(w_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    n_valid = 1'b0;
    w_valid = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_valid_dropped", 32'(result_valid), 32'd0);
    chk("bp_uop_ready_after", 32'(uop_ready), 32'd1);
    wait_idle();

    // N=0 with both stream valids held high: nothing consumed, result 0 next cycle
    nf0 = n_fires;
    wf0 = w_fires;
    n_valid = 1'b1;
    w_valid = 1'b1;
    exp_q.push_back(32'h0000_0000);
    send_uop(0, 1'b0, 1'b0);
    chk("n0_valid_next_cycle", 32'(result_valid), 32'd1);
    wait_idle();
    n_valid = 1'b0;
    w_valid = 1'b0;
    chk("n0_n_beats", 32'(n_fires - nf0), 32'd0);
    chk("n0_w_beats", 32'(w_fires - wf0), 32'd0);

    // Back-to-back N=1,3,0,2: 3*(-2)*32 = -192 per int16 beat; int8 5*2*64 = 640 per beat
    exp_q.push_back(32'hFFFF_FF40);
    exp_q.push_back(32'hFFFF_FDC0);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0500);
    send_uop(1, 1'b0, 1'b1);
    send_beats(1, {(DW/16){16'h0003}}, {(DW/16){16'hFFFE}}, 1'b0);
    send_uop(3, 1'b0, 1'b1);
    send_beats(3, {(DW/16){16'h0003}}, {(DW/16){16'hFFFE}}, 1'b0);
    send_uop(0, 1'b0, 1'b1);
    send_uop(2, 1'b1, 1'b1);
    send_beats(2, {(DW/8){8'h05}}, {(DW/8){8'h02}}, 1'b0);
    wait_idle();

    // Reset mid-ACC after 1 of 3 beats: no result, outputs quiet, then recovery
    send_uop(3, 1'b0, 1'b0);
    send_beats(1, {(DW/16){16'h0001}}, {(DW/16){16'h0002}}, 1'b0);
    n_valid = 1'b1;
    w_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk_quiet("mid_reset");
    n_valid = 1'b0;
    w_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_reset_no_result", 32'(result_valid), 32'd0);
    exp_q.push_back(32'h0000_0040);
    send_uop(1, 1'b0, 1'b0);
    send_beats(1, {(DW/16){16'h0001}}, {(DW/16){16'h0002}}, 1'b0);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_pe_mp.md
Name: matrix_pe_mp

Overview:
- Parametrised successor to the single-mode matrix PE: a multi-precision dot-product accumulator.
- Consumes one micro-op, then N beats of neuron and weight vectors from the NRAM/WRAM streams. Each beat is multiplied lane-wise, reduced and accumulated.
- Emits one 32-bit result through a valid/ready output; the previous generation had a valid-only output.
- Adds an int8 packed mode, optional saturation and result backpressure.

Parameters:
- DATA_W, 512: neuron/weight vector width; must be a multiple of 16.
- CNT_W, 6: width of the beat-count field in the uop.
- UOP_W, 8: uop width; must be ≥ CNT_W+2.
- ACC_W, 48: internal accumulator width; must hold DATA_W/16 × 2^30 × (2^CNT_W − 1).
- RES_W, 32: result width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ib_ctl_uop  in  UOP_W  micro-op
- ib_ctl_uop_valid  in  1  uop valid
- ib_ctl_uop_ready  out  1  uop ready
- nram_mpe_neuron  in  DATA_W  neuron vector
- nram_mpe_neuron_valid  in  1  neuron valid
- nram_mpe_neuron_ready  out  1  neuron ready
- wram_mpe_weight  in  DATA_W  weight vector
- wram_mpe_weight_valid  in  1  weight valid
- wram_mpe_weight_ready  out  1  weight ready
- result  out  RES_W  dot-product result
- result_valid  out  1  result valid
- result_ready  in  1  result ready

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset:
  - All readys = 0, result_valid = 0, result = 0, FSM in IDLE, accumulator and pipeline registers cleared.
  - Reset asserted mid-operation discards the in-flight op. No partial result is emitted.
- Uop fields:
  - [CNT_W-1:0] = N, the beat count.
  - [CNT_W] = mode: 0 = int16 (DATA_W/16 signed lanes), 1 = int8 (DATA_W/8 signed lanes).
  - [CNT_W+1] = sat: 1 = saturate, 0 = keep the low RES_W bits (two's-complement wrap).
  - Remaining bits are ignored.
- FSM states: IDLE, ACC, DRAIN, DONE.
- IDLE:
  - ib_ctl_uop_ready = 1.
  - On uop handshake: latch N/mode/sat and clear the accumulator.
  - N ≠ 0 → ACC. N = 0 → DONE with result 0 on the next cycle.
- ACC, joint beat handshake:
  - nram_mpe_neuron_ready = (ACC && wram_mpe_weight_valid).
  - wram_mpe_weight_ready = (ACC && nram_mpe_neuron_valid).
  - A beat fires only when both valids are high, so both streams advance together. A lone valid is never consumed.
  - Beat counter increments per fire. On the N-th fire → DRAIN.
- Datapath, 2 stages:
  - Stage 1 (registered at the fire edge): lane-wise signed products, sign-extended and reduced to one ACC_W partial sum.
  - Stage 2 (next edge): accumulator += partial sum.
- DRAIN waits until the last partial sum is accumulated, then → DONE.
- Latency: last beat fires at edge E → result_valid rises at edge E+2.
- DONE:
  - result_valid = 1.
  - result = sat ? clamp(acc, −2^(RES_W−1), 2^(RES_W−1)−1) : acc[RES_W-1:0].
  - result is held stable while result_ready = 0.
  - On the result handshake → IDLE. result_valid drops the next cycle and ib_ctl_uop_ready = 1 that cycle.
- No new uop is accepted before the result handshake completes.
- Input data stays unsampled outside a fire, so upstream may change it freely while not fired.
- Lane packing: lane i occupies bits [i·w+w−1 : i·w], w = 16 or 8.
- Stream readys are 0 in IDLE, DRAIN and DONE.

Test Plan:
- int16, N=1, every neuron lane 0x0001, weight lane 0x0002, sat=0 → result 0x00000040, result_valid exactly 2 cycles after the fire edge.
- int8, N=2, all neuron bytes 0xFF (−1), weight bytes 0x03 → result 0xFFFFFE80 (−384). Repeat with neuron/weight valids independently randomised (~50%): same result, exactly 2 beats consumed from each stream, never a lone-stream consume.
- int16, N=1, all lanes 0x7FFF×0x7FFF → sat=1 gives 0x7FFFFFFF; sat=0 gives 0xFFE00020.
- Backpressure: hold result_ready=0 for 5 cycles after result_valid → result/result_valid stable, ib_ctl_uop_ready=0, stream readys=0. Release → single handshake, uop_ready=1 the next cycle.
- N=0 uop → no stream beats consumed, result 0x00000000 valid one cycle after uop accept. Back-to-back four uops (N=1,3,0,2) → four results in order.
- rst pulsed mid-ACC after 1 of 3 beats → all outputs 0 on the following cycle, no result emitted. A fresh uop afterwards produces a correct result.
